redmule_tcdm_arbiter: RTL and testbench

- Round-robin arbiter that shares the single wide TCDM master port of the RedMulE accelerator among NumReq internal requesters, e.g. the streamer source and sink channels.
- Sits between the requesters and the top-level TCDM binding.
- Forwards one request per cycle and routes in-order read responses back to the requester that issued them, using an ID FIFO.

---
 rtl/redmule_pkg.sv | 18 +
 rtl/redmule_arb_id_fifo.sv | 60 ++++++
 rtl/redmule_tcdm_arbiter.sv | 135 +++++++++++++
 tb/tb_redmule_tcdm_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// Shared RedMulE definitions used by the TCDM arbiter and its ID FIFO.
package redmule_pkg;

  // Maximum number of read responses the arbiter keeps in flight.
  localparam int unsigned ARB_MAX_OUT = 4;

  // Meaning of the TCDM write-enable line (1 = read, 0 = write).
  typedef enum logic {
    TCDM_WRITE = 1'b0,
    TCDM_READ  = 1'b1
  } tcdm_op_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned arb_id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/redmule_arb_id_fifo.sv
// Pointer-based FIFO holding the requester index of every outstanding read.
// Depth must be a power of two (at least 2) so the pointers wrap naturally.
module redmule_arb_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned IdW   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [IdW-1:0]           data_in,
  output logic [IdW-1:0]           data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [IdW-1:0]  mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == CntW'(Depth));
  assign empty    = (count == '0);
  assign data_out = mem[rd_ptr];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Storage, pointers and occupancy; clear behaves exactly like reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/redmule_tcdm_arbiter.sv
// Round-robin arbiter sharing the single TCDM master port among NumReq
// requesters. Requests pass through combinationally; read responses come
// back in order and are routed using the ID FIFO.
//
// Handshake: a requester raises in_req_i with stable fields and holds them
// until it sees its in_gnt_o bit; a transfer happens in the cycle where
// tcdm_req_o and tcdm_gnt_i are both high, and the grant is reflected to
// the selected requester in that same cycle.
module redmule_tcdm_arbiter
  import redmule_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned DW     = 256,
  parameter int unsigned AW     = 32,
  parameter int unsigned MaxOut = ARB_MAX_OUT
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic [NumReq-1:0]              in_req_i,
  output logic [NumReq-1:0]              in_gnt_o,
  input  logic [NumReq-1:0][AW-1:0]      in_add_i,
  input  logic [NumReq-1:0]              in_wen_i,
  input  logic [NumReq-1:0][DW/8-1:0]    in_be_i,
  input  logic [NumReq-1:0][DW-1:0]      in_data_i,
  output logic [DW-1:0]                  in_r_data_o,
  output logic [NumReq-1:0]              in_r_valid_o,
  output logic                           tcdm_req_o,
  input  logic                           tcdm_gnt_i,
  output logic [AW-1:0]                  tcdm_add_o,
  output logic                           tcdm_wen_o,
  output logic [DW/8-1:0]                tcdm_be_o,
  output logic [DW-1:0]                  tcdm_data_o,
  input  logic [DW-1:0]                  tcdm_r_data_i,
  input  logic                           tcdm_r_valid_i,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int unsigned IdW  = arb_id_width(NumReq);
  localparam int unsigned CntW = $clog2(MaxOut) + 1;

  logic [IdW-1:0]  rr_ptr;
  logic [IdW-1:0]  sel;
  logic            any_req;
  logic            stall;
  logic            hs;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [IdW-1:0]  head_id;
  logic [CntW-1:0] fifo_count;

  // Pick the first active requester starting from rr_ptr, wrapping around.
  // The scan runs from the farthest offset down so the nearest one wins.
  always_comb begin
    int unsigned idx;
    sel     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (in_req_i[IdW'(idx)]) begin
        sel     = IdW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // A full ID FIFO blocks every request, writes too, even if a pop is due.
  assign stall       = fifo_full;
  assign tcdm_req_o  = any_req & ~stall;
  assign hs          = tcdm_req_o & tcdm_gnt_i;
  assign tcdm_add_o  = any_req ? in_add_i[sel]  : '0;
  assign tcdm_wen_o  = any_req ? in_wen_i[sel]  : 1'b0;
  assign tcdm_be_o   = any_req ? in_be_i[sel]   : '0;
  assign tcdm_data_o = any_req ? in_data_i[sel] : '0;
  assign in_r_data_o = tcdm_r_data_i;
  assign push        = hs & (tcdm_wen_o == TCDM_READ);
  assign pop         = tcdm_r_valid_i & ~fifo_empty;
  assign busy_o      = (fifo_count != '0);

  // Grant only the selected requester, and only on an actual handshake.
  always_comb begin
    in_gnt_o      = '0;
    in_gnt_o[sel] = hs;
  end

  // Route a response to the requester at the FIFO head; none when empty.
  always_comb begin
    in_r_valid_o          = '0;
    in_r_valid_o[head_id] = pop;
  end

  // Priority pointer advances past the winner only when it was served.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (clear_i) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (sel == IdW'(NumReq - 1)) ? '0 : sel + IdW'(1);
    end
  end

  // Sticky error: a response arrived while no read was outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (clear_i) begin
      err_o <= 1'b0;
    end else if (tcdm_r_valid_i && fifo_empty) begin
      err_o <= 1'b1;
    end
  end

  redmule_arb_id_fifo #(
    .Depth (MaxOut),
    .IdW   (IdW)
  ) i_id_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (clear_i),
    .push     (push),
    .pop      (pop),
    .data_in  (sel),
    .data_out (head_id),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Bench for redmule_tcdm_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_redmule_tcdm_arbiter;

  localparam int NREQ    = 2;
  localparam int DW      = 32;
  localparam int AW      = 16;
  localparam int MAX_OUT = 4;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          clear;
  logic [NREQ-1:0]               in_req;
  logic [NREQ-1:0]               in_gnt;
  logic [NREQ-1:0][AW-1:0]       in_add;
  logic [NREQ-1:0]               in_wen;
  logic [NREQ-1:0][DW/8-1:0]     in_be;
  logic [NREQ-1:0][DW-1:0]       in_data;
  logic [DW-1:0]                 in_r_data;
  logic [NREQ-1:0]               in_r_valid;
  logic                          tcdm_req;
  logic                          tcdm_gnt;
  logic [AW-1:0]                 tcdm_add;
  logic                          tcdm_wen;
  logic [DW/8-1:0]               tcdm_be;
  logic [DW-1:0]                 tcdm_data;
  logic [DW-1:0]                 tcdm_r_data;
  logic                          tcdm_r_valid;
  logic                          busy;
  logic                          err;

  int checks = 0;
  int errors = 0;

  // Reference model state: priority start, outstanding read owners, error.
  int ptr;
  int id_q[$];
  bit err_m;
  // Decisions recorded at the check point for the following clock edge.
  int              m_sel;
  bit              m_hs;
  bit              m_wen;
  logic [NREQ-1:0] m_gnt;

  // Clock
  always #5 clk = ~clk;

  redmule_tcdm_arbiter #(
    .NumReq (NREQ),
    .DW     (DW),
    .AW     (AW),
    .MaxOut (MAX_OUT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .in_req_i       (in_req),
    .in_gnt_o       (in_gnt),
    .in_add_i       (in_add),
    .in_wen_i       (in_wen),
    .in_be_i        (in_be),
    .in_data_i      (in_data),
    .in_r_data_o    (in_r_data),
    .in_r_valid_o   (in_r_valid),
    .tcdm_req_o     (tcdm_req),
    .tcdm_gnt_i     (tcdm_gnt),
    .tcdm_add_o     (tcdm_add),
    .tcdm_wen_o     (tcdm_wen),
    .tcdm_be_o      (tcdm_be),
    .tcdm_data_o    (tcdm_data),
    .tcdm_r_data_i  (tcdm_r_data),
    .tcdm_r_valid_i (tcdm_r_valid),
    .busy_o         (busy),
    .err_o          (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ptr   = 0;
    id_q  = {};
    err_m = 1'b0;
    m_hs  = 1'b0;
    m_gnt = '0;
    m_sel = 0;
    m_wen = 1'b0;
  endtask

  // Drive one requester with a fresh transaction (random be/data).
  task automatic set_req(input int i, input bit r, input bit wen, input logic [AW-1:0] a);
    in_req[i]  = r;
    in_wen[i]  = wen;
    in_add[i]  = a;
    in_be[i]   = 4'($urandom_range(0, 15));
    in_data[i] = $urandom;
  endtask

  task automatic idle_inputs();
    in_req       = '0;
    in_wen       = '0;
    in_add       = '0;
    in_be        = '0;
    in_data      = '0;
    tcdm_gnt     = 1'b0;
    tcdm_r_valid = 1'b0;
    tcdm_r_data  = '0;
  endtask

  // At the falling edge, compare every output against the model.
  task automatic check_cycle();
    bit              any;
    bit              exp_req;
    logic [NREQ-1:0] erv;
    @(negedge clk);
    any   = |in_req;
    m_sel = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (m_sel < 0 && in_req[i]) m_sel = i;
    end
    exp_req = any && (id_q.size() < MAX_OUT) && !rst;
    m_hs    = exp_req && tcdm_gnt;
    m_gnt   = '0;
    if (m_hs) m_gnt[m_sel] = 1'b1;
    m_wen = any ? in_wen[m_sel] : 1'b0;
    erv   = '0;
    if (tcdm_r_valid && id_q.size() > 0 && !rst) erv[id_q[0]] = 1'b1;
    chk("tcdm_req", 64'(tcdm_req), 64'(exp_req));
    chk("in_gnt", 64'(in_gnt), 64'(m_gnt));
    chk("tcdm_add", 64'(tcdm_add), any ? 64'(in_add[m_sel]) : 64'd0);
    chk("tcdm_wen", 64'(tcdm_wen), 64'(m_wen));
    chk("tcdm_be", 64'(tcdm_be), any ? 64'(in_be[m_sel]) : 64'd0);
    chk("tcdm_data", 64'(tcdm_data), any ? 64'(in_data[m_sel]) : 64'd0);
    chk("r_valid", 64'(in_r_valid), 64'(erv));
    chk("r_data", 64'(in_r_data), 64'(tcdm_r_data));
    chk("busy", 64'(busy), 64'(id_q.size() != 0));
    chk("err", 64'(err), 64'(err_m));
  endtask

  // Advance the model across the rising edge, then settle inputs after it.
  task automatic tick();
    @(posedge clk);
    if (rst || clear) begin
      model_reset();
    end else begin
      if (m_hs) ptr = (m_sel + 1) % NREQ;
      if (tcdm_r_valid) begin
        if (id_q.size() > 0) void'(id_q.pop_front());
        else err_m = 1'b1;
      end
      if (m_hs && m_wen) id_q.push_back(m_sel);
    end
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    in_req = '0;
    while (id_q.size() > 0 && guard < 2 * MAX_OUT) begin
      tcdm_r_valid = 1'b1;
      tcdm_r_data  = $urandom;
      check_cycle();
      tick();
      guard++;
    end
    chk("drain_done", 64'(id_q.size()), 64'd0);
    tcdm_r_valid = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cycle();
    tick();
    rst = 1'b0;

    // Fairness: both reading continuously, grants alternate.
    tcdm_gnt = 1'b1;
    set_req(0, 1, 1, 16'h0100);
    set_req(1, 1, 1, 16'h0200);
    check_cycle();
    chk("fair_gnt_a", 64'(in_gnt), 64'b01);
    tick();
    set_req(0, 1, 1, 16'h0104);
    check_cycle();
    chk("fair_gnt_b", 64'(in_gnt), 64'b10);
    tick();
    set_req(1, 1, 1, 16'h0204);
    check_cycle();
    chk("fair_gnt_c", 64'(in_gnt), 64'b01);
    tick();
    check_cycle();
    chk("fair_gnt_d", 64'(in_gnt), 64'b10);
    tick();
    in_req = '0;
    tcdm_gnt = 1'b0;
    tcdm_r_valid = 1'b1;
    tcdm_r_data = 32'hA;
    check_cycle();
    chk("fair_rv_a", 64'(in_r_valid), 64'b01);
    tick();
    tcdm_r_data = 32'hB;
    check_cycle();
    chk("fair_rv_b", 64'(in_r_valid), 64'b10);
    chk("fair_rdata_b", 64'(in_r_data), 64'hB);
    tick();
    drain();

    // Stall hold: no downstream grant, request and fields must wait.
    set_req(0, 1, 1, 16'h0300);
    tcdm_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_cycle();
      chk("stall_gnt", 64'(in_gnt), 64'b00);
      chk("stall_add", 64'(tcdm_add), 64'h0300);
      tick();
    end
    tcdm_gnt = 1'b1;
    check_cycle();
    chk("stall_release", 64'(in_gnt), 64'b01);
    tick();
    set_req(0, 1, 1, 16'h0304);
    set_req(1, 1, 1, 16'h0400);
    check_cycle();
    chk("ptr_moved", 64'(in_gnt), 64'b10);
    tick();
    drain();

    // FIFO full: four reads in flight block the fifth request.
    tcdm_gnt = 1'b1;
    for (int c = 0; c < MAX_OUT; c++) begin
      set_req(0, 1, 1, AW'(16'h0500 + 4 * c));
      check_cycle();
      chk("full_fill", 64'(in_gnt), 64'b01);
      tick();
    end
    set_req(0, 1, 1, 16'h0600);
    check_cycle();
    chk("full_req", 64'(tcdm_req), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    tick();
    tcdm_r_valid = 1'b1;
    tcdm_r_data = $urandom;
    check_cycle();
    chk("full_pop_req", 64'(tcdm_req), 64'd0);
    chk("full_pop_rv", 64'(in_r_valid), 64'b01);
    tick();
    tcdm_r_valid = 1'b0;
    check_cycle();
    chk("full_resume", 64'(tcdm_req), 64'd1);
    tick();
    drain();

    // Writes push nothing; an unsolicited response sets the sticky error.
    tcdm_gnt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_req(1, 1, 0, AW'(16'h0700 + 4 * c));
      check_cycle();
      chk("wr_gnt", 64'(in_gnt), 64'b10);
      tick();
      chk("wr_busy", 64'(busy), 64'd0);
    end
    in_req = '0;
    tcdm_r_valid = 1'b1;
    check_cycle();
    chk("unsol_rv", 64'(in_r_valid), 64'b00);
    tick();
    tcdm_r_valid = 1'b0;
    check_cycle();
    chk("err_set", 64'(err), 64'd1);
    tick();
    check_cycle();
    chk("err_sticky", 64'(err), 64'd1);
    tick();
    clear = 1'b1;
    check_cycle();
    tick();
    clear = 1'b0;
    check_cycle();
    chk("err_cleared", 64'(err), 64'd0);
    tick();

    // Asynchronous reset with two reads outstanding.
    set_req(0, 1, 1, 16'h0800);
    set_req(1, 1, 1, 16'h0900);
    check_cycle();
    tick();
    check_cycle();
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    in_req = '0;
    tcdm_gnt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_req", 64'(tcdm_req), 64'd0);
    chk("arst_gnt", 64'(in_gnt), 64'd0);
    chk("arst_add", 64'(tcdm_add), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    check_cycle();
    tick();
    rst = 1'b0;
    tcdm_r_valid = 1'b1;
    check_cycle();
    chk("late_rv", 64'(in_r_valid), 64'b00);
    tick();
    tcdm_r_valid = 1'b0;
    clear = 1'b1;
    check_cycle();
    chk("late_err", 64'(err), 64'd1);
    tick();
    clear = 1'b0;
    tcdm_gnt = 1'b1;
    set_req(0, 1, 1, 16'h0A00);
    set_req(1, 1, 1, 16'h0B00);
    check_cycle();
    chk("post_rst_gnt", 64'(in_gnt), 64'b01);
    tick();
    in_req = '0;
    drain();

    // Mixed traffic with responses two cycles after each read.
    tcdm_gnt = 1'b1;
    set_req(0, 1, 1, 16'h0C00);
    check_cycle();
    tick();
    in_req = '0;
    set_req(1, 1, 0, 16'h0D00);
    check_cycle();
    chk("mix_wr_gnt", 64'(in_gnt), 64'b10);
    tick();
    in_req = '0;
    set_req(0, 1, 1, 16'h0C04);
    tcdm_r_valid = 1'b1;
    tcdm_r_data = 32'h1111;
    check_cycle();
    chk("mix_rv_a", 64'(in_r_valid), 64'b01);
    tick();
    in_req = '0;
    tcdm_r_valid = 1'b0;
    check_cycle();
    tick();
    tcdm_r_valid = 1'b1;
    tcdm_r_data = 32'h2222;
    check_cycle();
    chk("mix_rv_b", 64'(in_r_valid), 64'b01);
    tick();
    tcdm_r_valid = 1'b0;
    check_cycle();
    chk("mix_idle", 64'(busy), 64'd0);
    tick();

    // Random traffic: requesters hold until granted, responses in order.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt[i] || !in_req[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1, 1'($urandom_range(0, 1)), AW'($urandom));
          else
            in_req[i] = 1'b0;
        end
      end
      tcdm_gnt     = ($urandom_range(0, 3) != 0);
      tcdm_r_valid = (id_q.size() > 0) && ($urandom_range(0, 2) == 0);
      tcdm_r_data  = $urandom;
      check_cycle();
      tick();
    end
    tcdm_gnt = 1'b0;
    drain();
    check_cycle();
    chk("final_err", 64'(err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
